// File: rtl/output_buffer_logic_pkg.sv
// Shared packet definitions for the byte-serial link: packet layout and
// transmit FSM state encoding.
package output_buffer_logic_pkg;

    localparam int PKT_BYTES = 4;
    localparam int BYTE_W    = 8;
    localparam int PKT_W     = PKT_BYTES * BYTE_W;

    // Byte 0 is the most significant byte and goes on the wire first.
    typedef logic [0:PKT_BYTES-1][BYTE_W-1:0] pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } tx_state_e;

endpackage

// File: rtl/output_buffer_logic_pkt_queue.sv
// Show-ahead circular packet queue: the head entry is visible combinationally
// on data_out whenever the queue is not empty.
module pkt_queue
    import output_buffer_logic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic                     re,
    input  pkt_t                     data_in,
    output pkt_t                     data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pkt_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Gating on registered full/empty means a pop never frees room for a
    // same-cycle push when full, and an empty queue never falls through.
    assign push_ok  = we && !full;
    assign pop_ok   = re && !empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/output_buffer_logic.sv
// Transmit side of the byte-serial link: queues packets and sends each as a
// 4-byte burst on payload/put_outbound, followed by a mandatory idle gap.
module output_buffer_logic
    import output_buffer_logic_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  pkt_t              pkt_in,
    input  logic              pkt_in_avail,
    input  logic              allow,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              put_outbound,
    output logic [BYTE_W-1:0] payload
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    tx_state_e        state;
    tx_state_e        state_nxt;
    logic             load;
    logic [1:0]       byte_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_byte;
    logic             gap_last;
    pkt_t             head;
    logic [PKT_W-1:0] shreg;
    logic [CNT_W-1:0] count;

    pkt_queue #(.DEPTH(DEPTH)) u_queue (
        .clock    (clock),
        .reset_n  (reset_n),
        .we       (pkt_in_avail),
        .re       (load),
        .data_in  (pkt_in),
        .data_out (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign last_byte = (byte_cnt == 2'd3);
    assign gap_last  = (gap_cnt == GAP_W'(GAP - 1));

    // The final gap cycle makes the IDLE decision itself, so consecutive
    // bursts are separated by exactly GAP low cycles.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty && allow) begin
                    load      = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (last_byte) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (gap_last) begin
                    if (!empty && allow) begin
                        load      = 1'b1;
                        state_nxt = ST_SEND;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            byte_cnt     <= '0;
            gap_cnt      <= '0;
            put_outbound <= 1'b0;
            payload      <= '0;
            overflow     <= 1'b0;
        end else begin
            state    <= state_nxt;
            overflow <= pkt_in_avail && (count == CNT_W'(DEPTH));
            if (load) begin
                put_outbound <= 1'b1;
                payload      <= head[0];
                byte_cnt     <= '0;
            end else if (state == ST_SEND && !last_byte) begin
                payload  <= shreg[PKT_W-1 -: BYTE_W];
                byte_cnt <= byte_cnt + 1'b1;
            end else begin
                put_outbound <= 1'b0;
                payload      <= '0;
            end
            if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
            else                 gap_cnt <= '0;
        end
    end

    // Byte 0 goes straight to payload at load; shreg holds the bytes still to send.
    always_ff @(posedge clock) begin
        if (load)
            shreg <= {head[1], head[2], head[3], {BYTE_W{1'b0}}};
        else if (state == ST_SEND)
            shreg <= {shreg[PKT_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    end

endmodule

// File: tb/tb_output_buffer_logic.sv
// Self-checking bench for output_buffer_logic: a queue-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_output_buffer_logic;
    import output_buffer_logic_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP   = 1;

    logic       clock        = 1'b0;
    logic       reset_n      = 1'b0;
    pkt_t       pkt_in       = '0;
    logic       pkt_in_avail = 1'b0;
    logic       allow        = 1'b0;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       put_outbound;
    logic [7:0] payload;

    always #5 clock = ~clock;

    output_buffer_logic #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pkt_in       (pkt_in),
        .pkt_in_avail (pkt_in_avail),
        .allow        (allow),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .put_outbound (put_outbound),
        .payload      (payload)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Reference model state: queued packets, bytes still owed on the wire,
    // and the number of consecutive idle output cycles ending now.
    logic [31:0] mq[$];
    logic [7:0]  tx[$];
    logic        m_ovf    = 1'b0;
    int          idle_run = GAP;

    logic [7:0]  rx[$];
    int          gaps[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic model_loop();
        bit          sending;
        bit          start;
        int          sz;
        logic [31:0] p;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                tx.delete();
                m_ovf    = 1'b0;
                idle_run = GAP;
            end else begin
                sz      = mq.size();
                sending = (tx.size() != 0);
                start   = !sending && (idle_run >= GAP) && (sz != 0) && allow;
                if (sending) void'(tx.pop_front());
                if (start) begin
                    p = mq.pop_front();
                    tx.push_back(p[31:24]);
                    tx.push_back(p[23:16]);
                    tx.push_back(p[15:8]);
                    tx.push_back(p[7:0]);
                end
                m_ovf = pkt_in_avail && (sz == DEPTH);
                if (pkt_in_avail && sz < DEPTH) mq.push_back(pkt_in);
                idle_run = (tx.size() != 0) ? 0 : idle_run + 1;
            end
        end
    endtask

    task automatic compare_loop();
        bit prev_put = 1'b0;
        bit seen     = 1'b0;
        int low_run  = 0;
        forever begin
            @(negedge clock);
            #1;
            if (cmp_en) begin
                check("cmp_put",      put_outbound, tx.size() != 0);
                check("cmp_payload",  payload, (tx.size() != 0) ? tx[0] : 8'h00);
                check("cmp_full",     full,     mq.size() == DEPTH);
                check("cmp_empty",    empty,    mq.size() == 0);
                check("cmp_overflow", overflow, m_ovf);
            end
            if (put_outbound === 1'b1) begin
                if (!prev_put && seen) gaps.push_back(low_run);
                rx.push_back(payload);
                low_run = 0;
                seen    = 1'b1;
            end else begin
                low_run++;
            end
            prev_put = (put_outbound === 1'b1);
        end
    endtask

    initial begin
        int base;
        int gbase;
        int k;
        fork
            model_loop();
            compare_loop();
        join_none

        // Reset values held for three cycles
        repeat (3) step();
        cmp_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_full",     full,         1'b0);
            check("rst_empty",    empty,        1'b1);
            check("rst_overflow", overflow,     1'b0);
            check("rst_put",      put_outbound, 1'b0);
            check("rst_payload",  payload,      8'h00);
            step();
        end
        reset_n = 1'b1;
        step();

        // Single packet latency and byte order
        allow        = 1'b1;
        pkt_in       = 32'hDEADBEEF;
        pkt_in_avail = 1'b1;
        step();
        pkt_in_avail = 1'b0;
        check("t2_put_t1",   put_outbound, 1'b0);
        check("t2_empty_t1", empty,        1'b0);
        step();
        check("t2_put_t2",   put_outbound, 1'b1);
        check("t2_byte0",    payload,      8'hDE);
        check("t2_empty_t2", empty,        1'b1);
        step();
        check("t2_byte1", payload, 8'hAD);
        step();
        check("t2_byte2", payload, 8'hBE);
        step();
        check("t2_byte3", payload, 8'hEF);
        check("t2_put_t5", put_outbound, 1'b1);
        step();
        check("t2_put_t6", put_outbound, 1'b0);
        check("t2_pay_t6", payload,      8'h00);
        repeat (3) step();

        // Three back-to-back packets
        base  = rx.size();
        gbase = gaps.size();
        pkt_in = 32'h01020304; pkt_in_avail = 1'b1; step();
        pkt_in = 32'h05060708; step();
        pkt_in = 32'h090A0B0C; step();
        pkt_in_avail = 1'b0;
        repeat (25) step();
        check("t3_rx_count", rx.size() - base, 12);
        for (int i = 0; i < 12; i++)
            if (base + i < rx.size()) check("t3_byte", rx[base + i], i + 1);
        check("t3_gap_count", gaps.size() - gbase, 3);
        if (gaps.size() >= gbase + 3) begin
            check("t3_gap1", gaps[gbase + 1], 1);
            check("t3_gap2", gaps[gbase + 2], 1);
        end

        // allow gating at burst start only
        allow  = 1'b0;
        base   = rx.size();
        pkt_in = 32'h11223344; pkt_in_avail = 1'b1; step();
        pkt_in_avail = 1'b0;
        repeat (10) step();
        check("t4_no_burst", rx.size() - base, 0);
        check("t4_queued",   empty,            1'b0);
        allow = 1'b1;
        step();
        check("t4_start_put",  put_outbound, 1'b1);
        check("t4_start_byte", payload,      8'h11);
        step();
        check("t4_byte1", payload, 8'h22);
        allow = 1'b0;
        step();
        check("t4_byte2", payload, 8'h33);
        step();
        check("t4_byte3", payload, 8'h44);
        repeat (3) step();
        check("t4_rx_count", rx.size() - base, 4);

        // Fill, overflow, then drain exactly DEPTH packets
        base = rx.size();
        for (int i = 0; i < 5; i++) begin
            pkt_in       = 32'hA0B0C0D0 + i;
            pkt_in_avail = 1'b1;
            step();
            if (i == 2) check("t5_not_full", full, 1'b0);
            if (i == 3) begin
                check("t5_full",    full,     1'b1);
                check("t5_no_ovf",  overflow, 1'b0);
            end
            if (i == 4) begin
                check("t5_ovf",        overflow, 1'b1);
                check("t5_still_full", full,     1'b1);
            end
        end
        pkt_in_avail = 1'b0;
        step();
        check("t5_ovf_pulse_end", overflow, 1'b0);
        allow = 1'b1;
        repeat (30) step();
        check("t5_rx_count", rx.size() - base, 16);
        if (rx.size() >= base + 16) begin
            check("t5_first_byte", rx[base],      8'hA0);
            check("t5_last_byte",  rx[base + 15], 8'hD3);
        end
        check("t5_empty", empty, 1'b1);

        // Asynchronous reset during byte 1 with two packets still queued
        allow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pkt_in       = 32'h5A000000 + i;
            pkt_in_avail = 1'b1;
            step();
        end
        pkt_in_avail = 1'b0;
        allow        = 1'b1;
        step();
        k = 0;
        while (put_outbound !== 1'b1 && k < 5) begin
            step();
            k++;
        end
        check("t6_burst_start", put_outbound, 1'b1);
        step();
        check("t6_byte1", payload, 8'h00);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_put",     put_outbound, 1'b0);
        check("t6_rst_empty",   empty,        1'b1);
        check("t6_rst_payload", payload,      8'h00);
        check("t6_rst_full",    full,         1'b0);
        base = rx.size();
        step();
        step();
        reset_n = 1'b1;
        repeat (20) step();
        check("t6_no_burst", rx.size() - base, 0);
        check("t6_empty",    empty,            1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
